// File: rtl/eth_tx_frame_buffer.sv
// Register-mapped Ethernet TX frame buffer: the CPU fills a byte buffer, writes TX_LEN and TX_SEND, and the
// frame streams out one byte per handshake. Optional macro ETH_TX_PAD_EN pads short frames with zeros to 60 bytes.
module eth_tx_frame_buffer #(
  parameter int data_width_p = 32,
  parameter int buf_bytes_p  = 2048
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [11:0]               addr_i,
  input  logic                      write_en_i,
  input  logic                      read_en_i,
  input  logic [data_width_p/8-1:0] write_mask_i,
  input  logic [data_width_p-1:0]   write_data_i,
  output logic [data_width_p-1:0]   read_data_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_v_o,
  output logic                      tx_last_o,
  input  logic                      tx_ready_i,
  output logic                      tx_interrupt_pending_o
);

  localparam int words_lp = buf_bytes_p / 4;
  localparam int aw_lp    = $clog2(words_lp);
  localparam logic [aw_lp-1:0] one_lp = 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_e;

  // tx stream: a byte transfers on any cycle where tx_v_o and tx_ready_i are both high; while tx_v_o is
  // high and tx_ready_i is low, tx_data_o and tx_last_o are held unchanged.
  state_e                    state_q, state_d;
  logic [11:0]               len_q, len_d;
  logic                      irq_pend_q, irq_pend_d;
  logic                      irq_en_q, irq_en_d;
  logic [data_width_p-1:0]   read_data_q, read_data_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_v_q, tx_v_d;
  logic                      tx_last_q, tx_last_d;
  logic [11:0]               byte_cnt_q, byte_cnt_d;
  logic [31:0]               cur_q, cur_d;
  logic [aw_lp-1:0]          fetch_q, fetch_d;

  logic [31:0]               mem [words_lp];
  logic [31:0]               rd_q;

  logic                      busy;
  logic                      wr_buf, wr_len, wr_irq_en, clr_irq, send_req;
  logic [aw_lp-1:0]          widx;
  logic [11:0]               len_wr, len_sat, total, last_idx, nb;
  logic [1:0]                lane;
  logic [31:0]               word_sel;
  logic [7:0]                next_byte;

  assign busy      = (state_q != IDLE);
  assign widx      = addr_i[aw_lp+1:2];
  assign wr_buf    = write_en_i && !addr_i[11] && !busy;
  assign wr_len    = write_en_i && (addr_i == 12'h800) && !busy;
  assign wr_irq_en = write_en_i && (addr_i == 12'h80C) && write_mask_i[0];
  assign clr_irq   = write_en_i && (addr_i == 12'h808) && write_mask_i[0] && write_data_i[0];
  assign send_req  = write_en_i && (addr_i == 12'h804) && write_mask_i[0] && write_data_i[0]
                     && !busy && (len_q != 12'd0);

  always_comb begin
    len_wr = len_q;
    if (write_mask_i[0]) len_wr[7:0]  = write_data_i[7:0];
    if (write_mask_i[1]) len_wr[11:8] = write_data_i[11:8];
    len_sat = len_wr;
    if ({1'b0, len_wr} > 13'(buf_bytes_p)) len_sat = 12'(buf_bytes_p);
  end

`ifdef ETH_TX_PAD_EN
  assign total = (len_q < 12'd60) ? 12'd60 : len_q;
`else
  assign total = len_q;
`endif
  assign last_idx = total - 12'd1;

  // The word after the current one sits in rd_q, so a lane wrap never costs a cycle.
  assign nb       = byte_cnt_q + 12'd1;
  assign lane     = nb[1:0];
  assign word_sel = (lane == 2'd0) ? rd_q : cur_q;

  always_comb begin
    next_byte = word_sel[{lane, 3'b000} +: 8];
`ifdef ETH_TX_PAD_EN
    if (nb >= len_q) next_byte = 8'h00;
`endif
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    irq_pend_d  = irq_pend_q;
    irq_en_d    = irq_en_q;
    read_data_d = read_data_q;
    tx_data_d   = tx_data_q;
    tx_v_d      = tx_v_q;
    tx_last_d   = tx_last_q;
    byte_cnt_d  = byte_cnt_q;
    cur_d       = cur_q;
    fetch_d     = fetch_q;

    if (read_en_i) begin
      read_data_d = '0;
      case (addr_i)
        12'h800: read_data_d[11:0] = len_q;
        12'h804: read_data_d[0]    = busy;
        12'h808: read_data_d[0]    = irq_pend_q;
        12'h80C: read_data_d[0]    = irq_en_q;
        default: read_data_d       = '0;
      endcase
    end

    if (wr_len)    len_d      = len_sat;
    if (wr_irq_en) irq_en_d   = write_data_i[0];
    if (clr_irq)   irq_pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        fetch_d = '0;
        if (send_req) state_d = FETCH;
      end
      FETCH: begin
        cur_d      = rd_q;
        tx_data_d  = rd_q[7:0];
        tx_v_d     = 1'b1;
        tx_last_d  = (total == 12'd1);
        byte_cnt_d = '0;
        fetch_d    = one_lp;
        state_d    = STREAM;
      end
      STREAM: begin
        if (tx_ready_i) begin
          if (byte_cnt_q == last_idx) begin
            tx_v_d     = 1'b0;
            tx_last_d  = 1'b0;
            tx_data_d  = 8'h00;
            irq_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            byte_cnt_d = nb;
            tx_data_d  = next_byte;
            tx_last_d  = (nb == last_idx);
            if (lane == 2'd0) begin
              cur_d   = rd_q;
              fetch_d = fetch_q + one_lp;
            end
          end
        end
      end
      DONE: begin
        // Held high through DONE so a clear landing here loses to the set.
        irq_pend_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      irq_pend_q  <= 1'b0;
      irq_en_q    <= 1'b0;
      read_data_q <= '0;
      tx_data_q   <= '0;
      tx_v_q      <= 1'b0;
      tx_last_q   <= 1'b0;
      byte_cnt_q  <= '0;
      cur_q       <= '0;
      fetch_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      irq_pend_q  <= irq_pend_d;
      irq_en_q    <= irq_en_d;
      read_data_q <= read_data_d;
      tx_data_q   <= tx_data_d;
      tx_v_q      <= tx_v_d;
      tx_last_q   <= tx_last_d;
      byte_cnt_q  <= byte_cnt_d;
      cur_q       <= cur_d;
      fetch_q     <= fetch_d;
    end
  end

  // Buffer RAM: byte-lane writes, registered read addressed by the next fetch index.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_buf && write_mask_i[l]) mem[widx][8*l +: 8] <= write_data_i[8*l +: 8];
    end
    rd_q <= mem[fetch_d];
  end

  assign read_data_o            = read_data_q;
  assign tx_data_o              = tx_data_q;
  assign tx_v_o                 = tx_v_q;
  assign tx_last_o              = tx_last_q;
  assign tx_interrupt_pending_o = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Bench for eth_tx_frame_buffer: byte-array reference model feeds an expected queue, a negedge monitor checks
// every streamed byte. Honours ETH_TX_PAD_EN the same way the design does.
module tb_eth_tx_frame_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic        write_en_i = 1'b0;
  logic        read_en_i = 1'b0;
  logic [3:0]  write_mask_i = '0;
  logic [31:0] write_data_i = '0;
  logic [31:0] read_data_o;
  logic [7:0]  tx_data_o;
  logic        tx_v_o;
  logic        tx_last_o;
  logic        tx_ready_i = 1'b1;
  logic        tx_interrupt_pending_o;

  eth_tx_frame_buffer #(.data_width_p(32), .buf_bytes_p(2048)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .write_en_i(write_en_i),
    .read_en_i(read_en_i), .write_mask_i(write_mask_i), .write_data_i(write_data_i),
    .read_data_o(read_data_o), .tx_data_o(tx_data_o), .tx_v_o(tx_v_o), .tx_last_o(tx_last_o),
    .tx_ready_i(tx_ready_i), .tx_interrupt_pending_o(tx_interrupt_pending_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // reference model and scoreboard
  logic [7:0] ref_mem [2048];
  int         ref_len = 0;
  logic [8:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;
  int         rdy_mode = 0;
  int         exp_first_cyc = -1;
  int         first_cyc = 0;
  int         frame_total = 0;
  bit         in_frame = 0;
  bit         frame_done = 0;
  bit         stall_prev = 0;
  logic [7:0] held_data;
  logic       held_last;
  logic [8:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int frame_bytes(input int len);
`ifdef ETH_TX_PAD_EN
    if (len < 60) return 60;
`endif
    return len;
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (!reset_i) begin
      stall_prev = 0;
      in_frame   = 0;
    end else if (tx_v_o) begin
      if (stall_prev) begin
        chk("stall_data", {24'h0, tx_data_o}, {24'h0, held_data});
        chk("stall_last", {31'h0, tx_last_o}, {31'h0, held_last});
      end
      if (!in_frame) begin
        in_frame  = 1;
        first_cyc = cyc;
        chk("first_valid_cycle", cyc, exp_first_cyc);
      end
      if (tx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h expected=none", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'h0, tx_data_o}, {24'h0, e[7:0]});
          chk("tx_last", {31'h0, tx_last_o}, {31'h0, e[8]});
        end
        if (tx_last_o) begin
          frame_done = 1;
          in_frame   = 0;
          if (rdy_mode == 0) chk("frame_cycles", cyc - first_cyc, frame_total - 1);
        end
        stall_prev = 0;
      end else begin
        stall_prev = 1;
        held_data  = tx_data_o;
        held_last  = tx_last_o;
      end
    end else begin
      stall_prev = 0;
    end
  end

  // ready driver
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // driver tasks
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    @(posedge clk_i);
    #1;
    addr_i = a; write_data_i = d; write_mask_i = m; write_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    write_en_i = 1'b0; write_mask_i = '0;
  endtask

  task automatic buf_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m, input bit model);
    if (model) begin
      for (int l = 0; l < 4; l++) if (m[l]) ref_mem[int'(a & 12'h7FC) + l] = d[8*l +: 8];
    end
    bus_wr(a, d, m);
  endtask

  task automatic set_len(input logic [11:0] v);
    ref_len = (int'(v) > 2048) ? 2048 : int'(v);
    bus_wr(12'h800, {20'h0, v}, 4'hF);
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string name);
    @(posedge clk_i);
    #1;
    addr_i = a; read_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    read_en_i = 1'b0;
    chk(name, read_data_o, exp);
  endtask

  task automatic send();
    @(posedge clk_i);
    #1;
    addr_i = 12'h804; write_data_i = 32'h1; write_mask_i = 4'hF; write_en_i = 1'b1;
    frame_done = 0;
    if (ref_len != 0) begin
      frame_total   = frame_bytes(ref_len);
      exp_first_cyc = cyc + 2;
      for (int i = 0; i < frame_total; i++)
        exp_q.push_back({(i == frame_total - 1), (i < ref_len) ? ref_mem[i] : 8'h00});
    end
    @(posedge clk_i);
    #1;
    write_en_i = 1'b0; write_mask_i = '0;
  endtask

  task automatic wait_last(input int bound);
    int n = 0;
    while (!frame_done && n < bound) begin
      @(posedge clk_i);
      n++;
    end
    if (!frame_done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=%0d expected=%0d", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input int bound);
    send();
    wait_last(bound);
    repeat (3) @(posedge clk_i);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic fill_random(input int nbytes);
    for (int w = 0; w < (nbytes + 3) / 4; w++) begin
      buf_wr(12'(4 * w), $urandom, 4'hF, 1);
      buf_wr(12'(4 * w), $urandom, 4'($urandom_range(0, 15)), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_tx_v", {31'h0, tx_v_o}, 0);
    chk("rst_tx_last", {31'h0, tx_last_o}, 0);
    chk("rst_tx_data", {24'h0, tx_data_o}, 0);
    chk("rst_read_data", read_data_o, 0);
    chk("rst_irq", {31'h0, tx_interrupt_pending_o}, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    rd_chk(12'h800, 32'h0, "rst_tx_len");
    rd_chk(12'h804, 32'h0, "rst_busy");
    rd_chk(12'h808, 32'h0, "rst_irq_pend");
    rd_chk(12'h80C, 32'h0, "rst_irq_en");

    // basic frame, back-to-back bytes
    buf_wr(12'h000, 32'h44332211, 4'hF, 1);
    buf_wr(12'h004, 32'h88776655, 4'hF, 1);
    set_len(12'd6);
    rdy_mode = 0;
    run_frame(200);
    chk("irq_masked", {31'h0, tx_interrupt_pending_o}, 0);
    rd_chk(12'h808, 32'h1, "irq_pend_after_frame");
    bus_wr(12'h808, 32'h1, 4'hF);
    rd_chk(12'h808, 32'h0, "irq_pend_cleared");
    rd_chk(12'h000, 32'h0, "buffer_read_zero");
    rd_chk(12'h810, 32'h0, "unmapped_read_zero");

    // same frame with stalls
    rdy_mode = 1;
    run_frame(400);

    // random frames, random backpressure
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 80);
      fill_random(len);
      set_len(12'(len));
      rdy_mode = $urandom_range(0, 2);
      run_frame(1000);
    end
    bus_wr(12'h808, 32'h1, 4'hF);

    // interrupt timing, clear, and clear colliding with DONE
    rdy_mode = 0;
    bus_wr(12'h80C, 32'h1, 4'hF);
    fill_random(4);
    set_len(12'd4);
    send();
    wait_last(200);
    @(negedge clk_i);
    chk("irq_after_last", {31'h0, tx_interrupt_pending_o}, 1);
    bus_wr(12'h808, 32'h1, 4'hF);
    chk("irq_cleared", {31'h0, tx_interrupt_pending_o}, 0);
    repeat (2) @(posedge clk_i);
    send();
    wait_last(200);
    #1;
    addr_i = 12'h808; write_data_i = 32'h1; write_mask_i = 4'hF; write_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    write_en_i = 1'b0; write_mask_i = '0;
    chk("irq_set_wins", {31'h0, tx_interrupt_pending_o}, 1);
    rd_chk(12'h808, 32'h1, "irq_pend_set_wins");
    bus_wr(12'h808, 32'h1, 4'hF);
    chk("irq_cleared2", {31'h0, tx_interrupt_pending_o}, 0);

    // zero length and saturation
    set_len(12'd0);
    send();
    repeat (10) @(posedge clk_i);
    rd_chk(12'h808, 32'h0, "len0_no_irq");
    chk("len0_no_irq_out", {31'h0, tx_interrupt_pending_o}, 0);
    set_len(12'hFFF);
    rd_chk(12'h800, 32'h800, "len_saturate_fff");
    set_len(12'h801);
    rd_chk(12'h800, 32'h800, "len_saturate_801");

    // short frame (padded when enabled)
    fill_random(12);
    set_len(12'd10);
    rdy_mode = 2;
    run_frame(1000);

    // busy writes ignored during a full-buffer frame
    for (int w = 0; w < 512; w++) buf_wr(12'(4 * w), $urandom, 4'hF, 1);
    set_len(12'h800);
    send();
    repeat (40) @(posedge clk_i);
    buf_wr(12'h000, 32'hFFFFFFFF, 4'hF, 0);
    buf_wr(12'h7FC, 32'hFFFFFFFF, 4'hF, 0);
    bus_wr(12'h800, 32'h8, 4'hF);
    bus_wr(12'h804, 32'h1, 4'hF);
    rd_chk(12'h804, 32'h1, "busy_flag");
    rd_chk(12'h800, 32'h800, "len_busy_unchanged");
    wait_last(8000);
    repeat (3) @(posedge clk_i);
    chk("big_queue_drained", exp_q.size(), 0);
    rd_chk(12'h800, 32'h800, "len_after_big");
    rd_chk(12'h804, 32'h0, "idle_after_big");
    set_len(12'd8);
    rdy_mode = 0;
    run_frame(200);

    // reset mid-frame, then a cold send
    set_len(12'd100);
    send();
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("abort_tx_v", {31'h0, tx_v_o}, 0);
    chk("abort_tx_last", {31'h0, tx_last_o}, 0);
    chk("abort_tx_data", {24'h0, tx_data_o}, 0);
    chk("abort_irq", {31'h0, tx_interrupt_pending_o}, 0);
    exp_q.delete();
    ref_len = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    rd_chk(12'h808, 32'h0, "abort_irq_pend");
    rd_chk(12'h800, 32'h0, "abort_tx_len");
    rd_chk(12'h804, 32'h0, "abort_busy");
    fill_random(8);
    set_len(12'd7);
    run_frame(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_buffer.md
ETH_TX_FRAME_BUFFER -- requirements
Module: eth_tx_frame_buffer

Interface
REQ-001 SHALL have parameters: data_width_p, default 32, register bus width; buf_bytes_p, default 2048, frame buffer capacity in bytes (power of 2, multiple of 4).
REQ-002 SHALL have ports, in this order:
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous active-low reset
- addr_i  in  12  byte address of register access
- write_en_i  in  1  write strobe, one access per cycle
- read_en_i  in  1  read strobe, never concurrent with write_en_i
- write_mask_i  in  data_width_p/8  byte-lane enables
- write_data_i  in  data_width_p  write data
- read_data_o  out  data_width_p  read data, synchronous
- tx_data_o  out  8  frame byte to MAC
- tx_v_o  out  1  tx_data_o valid
- tx_last_o  out  1  final byte of frame
- tx_ready_i  in  1  MAC accepts byte (ready/valid)
- tx_interrupt_pending_o  out  1  frame-sent interrupt

Function
REQ-003 SHALL decode: 0x000-0x7FF buffer (write-only, reads return 0); 0x800 TX_LEN rw [11:0]; 0x804 TX_SEND (write bit0=1 starts; read bit0=busy); 0x808 IRQ_PEND (read; write bit0=1 clears); 0x80C IRQ_EN rw bit0; other addresses read 0, writes ignored.
REQ-004 SHALL return read data on read_data_o exactly one cycle after read_en_i, holding it until the next read.
REQ-005 SHALL store buffer writes per byte lane per write_mask_i into word addr_i[10:2].
REQ-006 SHALL saturate TX_LEN writes above buf_bytes_p to buf_bytes_p.
REQ-007 SHALL ignore buffer, TX_LEN and TX_SEND writes while busy.
REQ-008 SHALL ignore TX_SEND when TX_LEN=0 (no stream, no interrupt).
REQ-009 SHALL implement FSM IDLE -> FETCH (send accepted) -> STREAM (first word loaded) -> DONE (last byte handshaked) -> IDLE (next cycle); busy = state != IDLE.
REQ-010 SHALL assert tx_v_o first in the second cycle after the TX_SEND write cycle.
REQ-011 SHALL emit bytes little-endian within each word (lane 0 first), byte index 0 to TX_LEN-1.
REQ-012 SHALL prefetch the next word so that with tx_ready_i held high one byte transfers every cycle, no bubbles.
REQ-013 SHALL hold tx_data_o, tx_last_o stable while tx_v_o=1 and tx_ready_i=0.
REQ-014 SHALL assert tx_last_o only with the byte of index TX_LEN-1 (or 59 when padding, REQ-019).
REQ-015 SHALL set IRQ_PEND in DONE; simultaneous set and clear-write: set wins.
REQ-016 SHALL drive tx_interrupt_pending_o = IRQ_PEND & IRQ_EN, combinationally from registers.

Reset
REQ-017 SHALL, while reset_i=0, force state IDLE, TX_LEN=0, IRQ_PEND=0, IRQ_EN=0, read_data_o=0, tx_v_o=0, tx_last_o=0, tx_data_o=0; buffer contents undefined.
REQ-018 SHALL abort an in-progress frame on reset with no interrupt; after release, first send behaves as from cold.

Configuration
REQ-019 SHALL, with ETH_TX_PAD_EN defined, extend frames with TX_LEN<60 by zero bytes to 60 bytes total; without it, exactly TX_LEN bytes are sent.

Verification
REQ-020 Write words 0x44332211, 0x88776655 at 0x000/0x004, TX_LEN=6, send, tx_ready_i=1 -> bytes 11,22,33,44,55,66 on 6 consecutive cycles, tx_last_o with 66, first tx_v_o two cycles after send.
REQ-021 Same frame, tx_ready_i toggling 1/0 -> identical byte order, data held stable during stalls.
REQ-022 IRQ_EN=1, frame of 4 bytes -> tx_interrupt_pending_o=1 one cycle after last handshake; write 1 to 0x808 -> 0 next cycle; clear coinciding with DONE -> stays 1.
REQ-023 Send with TX_LEN=0 -> tx_v_o stays 0, IRQ_PEND stays 0; write TX_LEN=0xFFF -> reads 0x800.
REQ-024 Busy writes: during 2048-byte frame write 0xFFFFFFFF to 0x000 and TX_LEN=8 -> streamed data and TX_LEN unchanged; reset_i low mid-frame -> tx_v_o=0 immediately, IRQ_PEND=0.
REQ-025 ETH_TX_PAD_EN defined, TX_LEN=10 -> 60 bytes, bytes 10-59 are 0x00, tx_last_o on byte 59.
